// File: rtl/bus_data_sync.sv
// bus_data_sync: receive-side bus synchronizer into the CLK domain.
// BUS_ENABLE passes through a NUM_STAGES flop chain. Its synchronized rising
// edge captures UNSYNC_BUS into SYNC_BUS and raises ENABLE_PULSE for one cycle.
// Optional feature macro: BUS_DATA_SYNC_OVR_EN. When defined, it adds the
// DATA_ACK input and a sticky OVERRUN flag. OVERRUN is set when a new capture
// lands while the previous one has not yet been acknowledged.

module bus_data_sync #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2     // legal range 2..4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
`ifdef BUS_DATA_SYNC_OVR_EN
    input  logic                 DATA_ACK,
    output logic                 OVERRUN,
`endif
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE
);

    logic [NUM_STAGES-1:0] sync_stage;
    logic                  sync_en;
    logic                  prev_en;
    logic                  en_edge;

    // Plain shift chain for the asynchronous enable; no logic between stages.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_stage <= '0;
        end else begin
            sync_stage <= {sync_stage[NUM_STAGES-2:0], BUS_ENABLE};
        end
    end

    assign sync_en = sync_stage[NUM_STAGES-1];

    // Delayed copy of the synchronized enable, used for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_en <= 1'b0;
        end else begin
            prev_en <= sync_en;
        end
    end

    // prev_en clears on reset. An enable still high after reset therefore
    // produces a fresh edge once the chain refills.
    assign en_edge = sync_en & ~prev_en;

    // Capture the bus and strobe once per synchronized rising edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SYNC_BUS     <= '0;
            ENABLE_PULSE <= 1'b0;
        end else if (en_edge) begin
            SYNC_BUS     <= UNSYNC_BUS;
            ENABLE_PULSE <= 1'b1;
        end else begin
            ENABLE_PULSE <= 1'b0;
        end
    end

`ifdef BUS_DATA_SYNC_OVR_EN
    logic pending;

    // Track unacknowledged captures. A new edge wins over a same-cycle ack,
    // because the ack refers to the data being replaced.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending <= 1'b0;
            OVERRUN <= 1'b0;
        end else if (en_edge) begin
            pending <= 1'b1;
            if (pending && !DATA_ACK) begin
                OVERRUN <= 1'b1;
            end
        end else if (DATA_ACK) begin
            pending <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bus_data_sync.sv
// Directed bench for bus_data_sync. It runs a NUM_STAGES=2 and a NUM_STAGES=3
// instance side by side on shared stimulus.

module tb_bus_data_sync;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] UNSYNC_BUS;
    logic       BUS_ENABLE;
    logic [7:0] SYNC_BUS, SYNC_BUS3;
    logic       ENABLE_PULSE, ENABLE_PULSE3;
`ifdef BUS_DATA_SYNC_OVR_EN
    logic       DATA_ACK;
    logic       OVERRUN, OVERRUN3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    bus_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(UNSYNC_BUS), .BUS_ENABLE(BUS_ENABLE),
`ifdef BUS_DATA_SYNC_OVR_EN
        .DATA_ACK(DATA_ACK), .OVERRUN(OVERRUN),
`endif
        .SYNC_BUS(SYNC_BUS), .ENABLE_PULSE(ENABLE_PULSE)
    );

    bus_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(3)) dut3 (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(UNSYNC_BUS), .BUS_ENABLE(BUS_ENABLE),
`ifdef BUS_DATA_SYNC_OVR_EN
        .DATA_ACK(DATA_ACK), .OVERRUN(OVERRUN3),
`endif
        .SYNC_BUS(SYNC_BUS3), .ENABLE_PULSE(ENABLE_PULSE3)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] data;
        logic       exp_p;
        logic [7:0] exp_bus;
        logic       exp_p3;
        logic [7:0] exp_bus3;
    } vec_t;

    vec_t vecs [30];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

`ifdef BUS_DATA_SYNC_OVR_EN
    task automatic do_reset();
        RST = 1'b1; BUS_ENABLE = 1'b0; UNSYNC_BUS = 8'h00; DATA_ACK = 1'b0;
        step(); step();
        RST = 1'b0;
    endtask

    // Enable rises at the first step; the edge is sampled at step index 2.
    task automatic xfer(input logic [7:0] d, input int ack_at);
        BUS_ENABLE = 1'b1; UNSYNC_BUS = d;
        for (int c = 0; c < 8; c++) begin
            DATA_ACK = (c == ack_at);
            step();
        end
        BUS_ENABLE = 1'b0; DATA_ACK = 1'b0; UNSYNC_BUS = 8'h00;
        for (int c = 0; c < 4; c++) step();
    endtask
`endif

    initial begin
        int np, np3;
        RST = 1'b1; BUS_ENABLE = 1'b0; UNSYNC_BUS = 8'h00;
`ifdef BUS_DATA_SYNC_OVR_EN
        DATA_ACK = 1'b0;
`endif
        // rst, en, data, pulse2, bus2, pulse3, bus3
        vecs[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 8'h3C};
        vecs[8]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0, 8'h3C};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h3C};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h3C};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h3C};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h3C};
        // reset one cycle after enable rises, enable kept high
        vecs[13] = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h3C, 1'b0, 8'h3C};
        vecs[14] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[16] = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[17] = '{1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b0, 8'h00};
        vecs[18] = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h5A, 1'b1, 8'h5A};
        vecs[19] = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h5A, 1'b0, 8'h5A};
        // single sampled low cycle re-arms the edge detector
        vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0, 8'h5A};
        vecs[21] = '{1'b0, 1'b1, 8'hE7, 1'b0, 8'h5A, 1'b0, 8'h5A};
        vecs[22] = '{1'b0, 1'b1, 8'hE7, 1'b0, 8'h5A, 1'b0, 8'h5A};
        vecs[23] = '{1'b0, 1'b1, 8'hE7, 1'b1, 8'hE7, 1'b0, 8'h5A};
        vecs[24] = '{1'b0, 1'b1, 8'hE7, 1'b0, 8'hE7, 1'b1, 8'hE7};
        vecs[25] = '{1'b0, 1'b1, 8'hE7, 1'b0, 8'hE7, 1'b0, 8'hE7};
        // falling edge never pulses
        vecs[26] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hE7, 1'b0, 8'hE7};
        vecs[27] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hE7, 1'b0, 8'hE7};
        vecs[28] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hE7, 1'b0, 8'hE7};
        vecs[29] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hE7, 1'b0, 8'hE7};

        for (int i = 0; i < 30; i++) begin
            RST = vecs[i].rst; BUS_ENABLE = vecs[i].en; UNSYNC_BUS = vecs[i].data;
            step();
            chk($sformatf("vec%0d pulse", i),  32'(ENABLE_PULSE),  32'(vecs[i].exp_p));
            chk($sformatf("vec%0d bus", i),    32'(SYNC_BUS),      32'(vecs[i].exp_bus));
            chk($sformatf("vec%0d pulse3", i), 32'(ENABLE_PULSE3), 32'(vecs[i].exp_p3));
            chk($sformatf("vec%0d bus3", i),   32'(SYNC_BUS3),     32'(vecs[i].exp_bus3));
        end

        // Long enable: one pulse only, then re-arm after a 2-cycle drop.
        np = 0; np3 = 0;
        BUS_ENABLE = 1'b1; UNSYNC_BUS = 8'h44;
        for (int c = 0; c < 20; c++) begin
            step();
            if (ENABLE_PULSE)  np++;
            if (ENABLE_PULSE3) np3++;
        end
        chk("long pulses", 32'(np), 32'd1);
        chk("long pulses3", 32'(np3), 32'd1);
        chk("long bus", 32'(SYNC_BUS), 32'h44);
        BUS_ENABLE = 1'b0; UNSYNC_BUS = 8'h00;
        step(); step();
        np = 0; np3 = 0;
        BUS_ENABLE = 1'b1; UNSYNC_BUS = 8'h81;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ENABLE_PULSE)  np++;
            if (ENABLE_PULSE3) np3++;
        end
        chk("rearm pulses", 32'(np), 32'd1);
        chk("rearm pulses3", 32'(np3), 32'd1);
        chk("rearm bus", 32'(SYNC_BUS), 32'h81);
        chk("rearm bus3", 32'(SYNC_BUS3), 32'h81);
        BUS_ENABLE = 1'b0; UNSYNC_BUS = 8'h00;
        for (int c = 0; c < 4; c++) step();

`ifdef BUS_DATA_SYNC_OVR_EN
        do_reset();
        chk("ovr reset", 32'(OVERRUN), 32'd0);
        xfer(8'h11, -1);
        chk("ovr after first", 32'(OVERRUN), 32'd0);
        xfer(8'h22, -1);
        chk("ovr no ack", 32'(OVERRUN), 32'd1);
        chk("ovr newest data", 32'(SYNC_BUS), 32'h22);

        do_reset();
        xfer(8'h11, 4);
        xfer(8'h22, -1);
        chk("ovr acked", 32'(OVERRUN), 32'd0);
        xfer(8'h33, -1);
        chk("ovr third unacked", 32'(OVERRUN), 32'd1);

        do_reset();
        xfer(8'h11, -1);
        xfer(8'h22, 2);
        chk("ovr same-cycle ack", 32'(OVERRUN), 32'd0);
        chk("ovr same-cycle bus", 32'(SYNC_BUS), 32'h22);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
